// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter for the register-file write port. Grants
//               MEM > FPU FIFO head > ALU, drives one registered write per
//               cycle, buffers FPU results and tracks pending destinations.
//               Optional macro WB_FPU_BYPASS_EN lets an FPU result skip an
//               empty FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_rd,
    input  logic [31:0] fpu_data,
    output logic        fpu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic        mem_fpu,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_fpu,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_fpu_id,
    input  logic        rs2_fpu_id,
    output logic        hazard_stall,
    output logic [4:0]  rd_wb,
    output logic [31:0] write_data_register_wb,
    output logic [1:0]  regwrite_wb
);

    localparam logic [1:0] c_WB_NONE = 2'b00;
    localparam logic [1:0] c_WB_INT  = 2'b01;
    localparam logic [1:0] c_WB_FP   = 2'b10;

    logic [4:0]   r_fifo_rd   [FIFO_DEPTH];
    logic [31:0]  r_fifo_data [FIFO_DEPTH];
    logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
    logic [31:0]  r_pend_int, r_pend_fp;

    logic         w_empty, w_full, w_push, w_pop, w_bypass;
    logic         w_wr_en, w_wr_fpu;
    logic [4:0]   w_wr_rd;
    logic [31:0]  w_wr_data;
    logic [31:0]  w_clr_int, w_clr_fp, w_set_int, w_set_fp;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

`ifdef WB_FPU_BYPASS_EN
    assign w_bypass = w_empty && !mem_valid && fpu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push    = fpu_valid && !w_full && !w_bypass;
    assign w_pop     = !mem_valid && !w_empty;
    assign fpu_ready = !w_full;
    assign mem_ready = 1'b1;
    assign alu_ready = !mem_valid && w_empty && !w_bypass;

    // Grant selection; integer x0 writes are consumed without a write enable.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_fpu  = 1'b0;
        w_wr_rd   = 5'd0;
        w_wr_data = 32'd0;
        if (mem_valid) begin
            w_wr_fpu  = mem_fpu;
            w_wr_rd   = mem_rd;
            w_wr_data = mem_data;
            w_wr_en   = mem_fpu || (mem_rd != 5'd0);
        end else if (!w_empty) begin
            w_wr_fpu  = 1'b1;
            w_wr_rd   = r_fifo_rd[r_rd_ptr[PTR_W-1:0]];
            w_wr_data = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
            w_wr_en   = 1'b1;
        end else if (w_bypass) begin
            w_wr_fpu  = 1'b1;
            w_wr_rd   = fpu_rd;
            w_wr_data = fpu_data;
            w_wr_en   = 1'b1;
        end else if (alu_valid) begin
            w_wr_rd   = alu_rd;
            w_wr_data = alu_data;
            w_wr_en   = (alu_rd != 5'd0);
        end
    end

    always_comb begin
        w_clr_int = 32'd0;
        w_clr_fp  = 32'd0;
        w_set_int = 32'd0;
        w_set_fp  = 32'd0;
        if (w_wr_en) begin
            if (w_wr_fpu) w_clr_fp[w_wr_rd]  = 1'b1;
            else          w_clr_int[w_wr_rd] = 1'b1;
        end
        if (issue_valid) begin
            if (issue_fpu)               w_set_fp[issue_rd]  = 1'b1;
            else if (issue_rd != 5'd0)   w_set_int[issue_rd] = 1'b1;
        end
    end

    assign hazard_stall = (rs1_fpu_id ? r_pend_fp[rs1_id] : r_pend_int[rs1_id]) |
                          (rs2_fpu_id ? r_pend_fp[rs2_id] : r_pend_int[rs2_id]);

    // FIFO storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr[PTR_W-1:0]]   <= fpu_rd;
            r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= fpu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr               <= '0;
            r_rd_ptr               <= '0;
            r_pend_int             <= 32'd0;
            r_pend_fp              <= 32'd0;
            regwrite_wb            <= c_WB_NONE;
            rd_wb                  <= 5'd0;
            write_data_register_wb <= 32'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Set after clear: a newer producer keeps the bit pending.
            r_pend_int <= (r_pend_int & ~w_clr_int) | w_set_int;
            r_pend_fp  <= (r_pend_fp  & ~w_clr_fp)  | w_set_fp;
            if (w_wr_en) begin
                regwrite_wb            <= w_wr_fpu ? c_WB_FP : c_WB_INT;
                rd_wb                  <= w_wr_rd;
                write_data_register_wb <= w_wr_data;
            end else begin
                regwrite_wb            <= c_WB_NONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: directed scenarios then
//               random traffic against a queue-based reference model.
//               Honours WB_FPU_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_FPU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, fpu_valid, mem_valid, mem_fpu, issue_valid, issue_fpu;
    logic [4:0]  alu_rd, fpu_rd, mem_rd, issue_rd, rs1_id, rs2_id;
    logic        rs1_fpu_id, rs2_fpu_id;
    logic [31:0] alu_data, fpu_data, mem_data;
    logic        alu_ready, fpu_ready, mem_ready, hazard_stall;
    logic [4:0]  rd_wb;
    logic [31:0] write_data_register_wb;
    logic [1:0]  regwrite_wb;

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) u_dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_fpu(mem_fpu), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fpu(issue_fpu),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_fpu_id(rs1_fpu_id), .rs2_fpu_id(rs2_fpu_id),
        .hazard_stall(hazard_stall),
        .rd_wb(rd_wb), .write_data_register_wb(write_data_register_wb),
        .regwrite_wb(regwrite_wb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending FPU results in order, plus pending-register sets.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t      fq[$];
    bit [31:0] pend_i, pend_f;

    function automatic bit pending(input bit f, input logic [4:0] r);
        return f ? pend_f[r] : pend_i[r];
    endfunction

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        fpu_valid = 0; fpu_rd = 0; fpu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_fpu = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0; issue_fpu = 0;
        rs1_id = 0; rs2_id = 0; rs1_fpu_id = 0; rs2_fpu_id = 0;
    endtask

    // One clock: check combinational outputs, predict the write, clock, check it.
    task automatic step();
        bit          byp, wen, wf;
        logic [4:0]  wrd;
        logic [31:0] wd;
        ent_t        e;
        #1;
        byp = BYP && (fq.size() == 0) && !mem_valid && fpu_valid;
        check("fpu_ready", 32'(fpu_ready), 32'(fq.size() < DEPTH));
        check("mem_ready", 32'(mem_ready), 32'd1);
        check("alu_ready", 32'(alu_ready), 32'(!mem_valid && fq.size() == 0 && !byp));
        check("hazard_stall", 32'(hazard_stall),
              32'(pending(rs1_fpu_id, rs1_id) | pending(rs2_fpu_id, rs2_id)));
        wen = 0; wf = 0; wrd = 0; wd = 0;
        if (mem_valid) begin
            wf = mem_fpu; wrd = mem_rd; wd = mem_data; wen = mem_fpu || (mem_rd != 0);
        end else if (fq.size() > 0) begin
            e = fq.pop_front();
            wf = 1; wrd = e.rd; wd = e.d; wen = 1;
        end else if (byp) begin
            wf = 1; wrd = fpu_rd; wd = fpu_data; wen = 1;
        end else if (alu_valid) begin
            wrd = alu_rd; wd = alu_data; wen = (alu_rd != 0);
        end
        if (fpu_valid && !byp) fq.push_back({fpu_rd, fpu_data});
        if (wen) begin
            if (wf) pend_f[wrd] = 1'b0;
            else    pend_i[wrd] = 1'b0;
        end
        if (issue_valid) begin
            if (issue_fpu)          pend_f[issue_rd] = 1'b1;
            else if (issue_rd != 0) pend_i[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("regwrite_wb", 32'(regwrite_wb), wen ? (wf ? 32'd2 : 32'd1) : 32'd0);
        if (wen) begin
            check("rd_wb", 32'(rd_wb), 32'(wrd));
            check("write_data", write_data_register_wb, wd);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        pend_i = 0; pend_f = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_regwrite", 32'(regwrite_wb), 32'd0);
        check("reset_rd", 32'(rd_wb), 32'd0);
        check("reset_data", write_data_register_wb, 32'd0);
        check("reset_fpu_ready", 32'(fpu_ready), 32'd1);
        rst = 1'b0;

        // ALU alone, then an x0 write that must be swallowed
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; step();
        alu_rd = 0; alu_data = 32'hFFFF; step();
        idle_inputs(); step();

        // MEM/FPU conflict; an ALU request waits behind the FIFO
        mem_valid = 1; mem_fpu = 1; mem_rd = 3; mem_data = 32'hAAAA;
        fpu_valid = 1; fpu_rd = 7; fpu_data = 32'hBBBB; step();
        idle_inputs(); alu_valid = 1; alu_rd = 10; alu_data = 32'h77; step();
        idle_inputs(); step();

        // Fill the FIFO while MEM holds the port, then drain it
        mem_valid = 1; mem_rd = 1; mem_data = 32'h5555;
        for (int i = 0; i < DEPTH; i++) begin
            fpu_valid = 1; fpu_rd = 5'(20 + i); fpu_data = 32'h100 + 32'(i); step();
        end
        fpu_valid = 0; step();
        idle_inputs();
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Scoreboard: int 9 pending until its write, FP 9 independent
        issue_valid = 1; issue_rd = 9; step();
        idle_inputs(); rs1_id = 9; step(); step();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9; step();
        alu_valid = 0; step();
        issue_valid = 1; issue_fpu = 1; issue_rd = 9; step();
        idle_inputs(); rs1_id = 9; step();
        rs2_id = 9; rs2_fpu_id = 1; step();
        idle_inputs(); mem_valid = 1; mem_fpu = 1; mem_rd = 9; step();

        // Set/clear collision on int 4
        idle_inputs(); issue_valid = 1; issue_rd = 4; step();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44; step();
        idle_inputs(); rs2_id = 4; step();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h45; step();
        alu_valid = 0; step();

        // Asynchronous reset with two FIFO entries and a pending register
        idle_inputs(); mem_valid = 1; mem_rd = 2;
        fpu_valid = 1; fpu_rd = 11; fpu_data = 32'hB11; issue_valid = 1; issue_rd = 9; step();
        fpu_rd = 12; fpu_data = 32'hB12; issue_valid = 0; step();
        idle_inputs(); rs1_id = 9;
        #2 rst = 1'b1;
        #1;
        check("async_regwrite", 32'(regwrite_wb), 32'd0);
        check("async_rd", 32'(rd_wb), 32'd0);
        check("async_data", write_data_register_wb, 32'd0);
        check("async_fpu_ready", 32'(fpu_ready), 32'd1);
        check("async_hazard", 32'(hazard_stall), 32'd0);
        fq.delete(); pend_i = 0; pend_f = 0;
        #1 rst = 1'b0;
        fpu_valid = 1; fpu_rd = 13; fpu_data = 32'hC13; step();
        idle_inputs(); step(); step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            mem_valid   = ($urandom_range(3) == 0);
            mem_fpu     = 1'($urandom);
            mem_rd      = 5'($urandom_range(7));
            mem_data    = $urandom;
            fpu_valid   = (fq.size() < DEPTH) && ($urandom_range(2) == 0);
            fpu_rd      = 5'($urandom_range(7));
            fpu_data    = $urandom;
            alu_valid   = 1'($urandom);
            alu_rd      = 5'($urandom_range(7));
            alu_data    = $urandom;
            issue_valid = ($urandom_range(2) == 0);
            issue_fpu   = 1'($urandom);
            issue_rd    = 5'($urandom_range(7));
            rs1_id      = 5'($urandom_range(7));
            rs2_id      = 5'($urandom_range(7));
            rs1_fpu_id  = 1'($urandom);
            rs2_fpu_id  = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Producer side of the register-file write port: collects completed results from the ALU, FPU and load unit.
- Arbitrates between them and drives the single registered writeback (rd_wb, write_data_register_wb, regwrite_wb) into the integer/FP register file.
- Holds a scoreboard of in-flight destinations, so ID stalls on operands that are not yet written.
- Buffers multi-cycle FPU results in a small FIFO, so the FPU never blocks on a port conflict.

Parameters:
- FIFO_DEPTH, 4, number of entries in the FPU result FIFO (power of 2, minimum 2).
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result valid (integer destination).
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- fpu_valid  in  1  FPU result valid (FP destination).
- fpu_rd  in  5  FPU destination register.
- fpu_data  in  32  FPU result.
- fpu_ready  out  1  FIFO not full.
- mem_valid  in  1  load data valid.
- mem_rd  in  5  load destination register.
- mem_fpu  in  1  load targets the FP file (flw).
- mem_data  in  32  load data.
- mem_ready  out  1  load accepted; always 1.
- issue_valid  in  1  instruction with a register destination leaves ID.
- issue_rd  in  5  its destination.
- issue_fpu  in  1  destination is in the FP file.
- rs1_id, rs2_id  in  5 each  ID source registers.
- rs1_fpu_id, rs2_fpu_id  in  1 each  source file select.
- hazard_stall  out  1  a source register of the ID instruction is pending.
- rd_wb  out  5  writeback destination.
- write_data_register_wb  out  32  writeback data.
- regwrite_wb  out  2  writeback enable: 00 none, 01 integer file, 10 FP file.

Behaviour:
- Reset (async, rst=1): regwrite_wb=00, rd_wb=0, write_data_register_wb=0; FIFO empty; all scoreboard bits cleared.
  - Reset mid-operation discards FIFO contents and pending bits.
- Grant priority each cycle: MEM > FIFO head > ALU. Exactly one source is granted, or none.
  - MEM is always granted when mem_valid=1, so mem_ready=1.
  - alu_ready = !mem_valid && fifo_empty.
  - FIFO pops only when !mem_valid.
- Output latency:
  - The granted source loads the output registers at the next rising edge. regwrite_wb holds for exactly one cycle per write, otherwise 00.
  - MEM/ALU accept-to-write latency is 1 cycle.
  - FPU minimum latency is 2 cycles: enqueue, then pop.
- Integer x0 writes (ALU, or MEM with mem_fpu=0, rd=0) are consumed but produce regwrite_wb=00.
- FIFO:
  - Circular buffer with PTR_W+1-bit read/write pointers; full when the MSBs differ and the low bits are equal.
  - fpu_ready = !full, combinational from registered state.
  - Push and pop in the same cycle leave the count unchanged. Push while full cannot occur.
- Scoreboard: 32 integer and 32 FP pending bits.
  - Set on issue_valid for (issue_fpu, issue_rd); integer rd 0 is never set.
  - Cleared on the edge that loads a write to the same file and rd.
  - Same-edge set and clear of the same bit: set wins (newer producer).
- hazard_stall (combinational): pending[rs1_fpu_id][rs1_id] | pending[rs2_fpu_id][rs2_id].
  - A value visible on rd_wb is no longer pending; the register file forwards it.

Optional Feature:
- Macro WB_FPU_BYPASS_EN.
- Defined: when the FIFO is empty, mem_valid=0 and fpu_valid=1, the FPU result goes directly to the output registers and is not enqueued.
  - FPU latency becomes 1 cycle.
  - alu_ready additionally requires that no bypass occurs that cycle (FPU wins over ALU).
- Undefined: every FPU result passes through the FIFO.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with the FIFO holding 2 entries -> outputs 0 immediately, fpu_ready=1, hazard_stall=0; deassert and push 1 entry -> written 2 cycles later.
- ALU alone: alu_valid, rd=5, data=0x1234 -> next cycle regwrite_wb=01, rd_wb=5, data=0x1234; rd=0 -> regwrite_wb stays 00.
- Conflict: mem_valid (rd=3, mem_fpu=1, 0xAAAA) and fpu_valid (rd=7, 0xBBBB) in the same cycle -> cycle+1 writes FP 3=0xAAAA, cycle+2 writes FP 7=0xBBBB; alu_ready=0 while the FIFO is non-empty.
- FIFO full: hold mem_valid=1 and push 4 FPU results -> fpu_ready=0 after the 4th; drop mem_valid -> 4 writes in order, fpu_ready returns to 1 after the first pop.
- Scoreboard: issue int rd=9, then ID rs1=9 -> hazard_stall=1 until the cycle after the ALU result for rd=9 is accepted; issue FP rd=9 -> int rs1=9 does not stall.
- Set/clear collision: issue int rd=4 on the same edge the write to int 4 loads -> bit stays set, stall persists until the second write.
